zero_event_monitor: RTL and testbench

//  Consumes the per-cycle detection flag of the Mealy zero detector (its y_out) on the same clock.

---
 rtl/zero_event_monitor.sv | 136 +++++++++++++
 tb/tb_zero_event_monitor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_event_monitor.sv
// Windowed statistics on the zero-detector flag: event count, current/longest run of
// back-to-back detections, and a sticky threshold alarm held until acknowledged.
module zero_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             y_in,
    input  logic             clear,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic             busy,
    output logic             alarm,
    output logic             window_done
);

    localparam int SW = $clog2(WINDOW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [63:0]      THRESH_U = 64'(THRESH);
    localparam logic [63:0]      MAX_U    = 64'(CNT_MAX);
    // A threshold above the saturation value can never be reached.
    localparam bit THRESH_REACHABLE = (THRESH_U <= MAX_U);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW_S = 2'd1,
        ALARM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] event_count_reg, event_count_next;
    logic [CNT_W-1:0] run_len_reg, run_len_next;
    logic [CNT_W-1:0] max_run_reg, max_run_next;
    logic [SW-1:0]    sample_cnt_reg, sample_cnt_next;
    logic             busy_reg, alarm_reg, window_done_reg;

    logic [CNT_W-1:0] event_count_upd, run_len_upd, max_run_upd;
    logic             thresh_hit, last_sample;

    // Candidate counter values if the current y_in sample is accepted.
    always_comb begin
        event_count_upd = event_count_reg;
        run_len_upd     = '0;
        if (y_in) begin
            if (event_count_reg != CNT_MAX) begin
                event_count_upd = event_count_reg + 1'b1;
            end
            run_len_upd = (run_len_reg == CNT_MAX) ? run_len_reg : run_len_reg + 1'b1;
        end
        max_run_upd = (run_len_upd > max_run_reg) ? run_len_upd : max_run_reg;
    end

    assign thresh_hit  = THRESH_REACHABLE && (64'(event_count_upd) >= THRESH_U);
    assign last_sample = (sample_cnt_reg == SW'(WINDOW - 1));

    always_comb begin
        state_next       = state_reg;
        event_count_next = event_count_reg;
        run_len_next     = run_len_reg;
        max_run_next     = max_run_reg;
        sample_cnt_next  = sample_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next       = WINDOW_S;
                    event_count_next = '0;
                    run_len_next     = '0;
                    max_run_next     = '0;
                    sample_cnt_next  = '0;
                end
            end
            WINDOW_S: begin
                // Dropping enable aborts the window and discards this edge's sample.
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    event_count_next = event_count_upd;
                    run_len_next     = run_len_upd;
                    max_run_next     = max_run_upd;
                    sample_cnt_next  = sample_cnt_reg + 1'b1;
                    if (thresh_hit) begin
                        state_next = ALARM;
                    end else if (last_sample) begin
                        state_next = DONE;
                    end
                end
            end
            ALARM: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            event_count_reg <= '0;
            run_len_reg     <= '0;
            max_run_reg     <= '0;
            sample_cnt_reg  <= '0;
            busy_reg        <= 1'b0;
            alarm_reg       <= 1'b0;
            window_done_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            event_count_reg <= event_count_next;
            run_len_reg     <= run_len_next;
            max_run_reg     <= max_run_next;
            sample_cnt_reg  <= sample_cnt_next;
            busy_reg        <= (state_next == WINDOW_S);
            alarm_reg       <= (state_next == ALARM);
            window_done_reg <= (state_next == DONE);
        end
    end

    assign event_count = event_count_reg;
    assign run_len     = run_len_reg;
    assign max_run     = max_run_reg;
    assign busy        = busy_reg;
    assign alarm       = alarm_reg;
    assign window_done = window_done_reg;

endmodule

// File: tb/tb_zero_event_monitor.sv
// Randomized self-checking bench: window outcomes are predicted from the sample
// sequence itself (prefix counts and run lengths), independent of any FSM model.
module tb_zero_event_monitor;

    logic clk = 1'b0;
    logic reset, enable, y_in, clear;
    logic [7:0] a_ev, a_run, a_max;
    logic a_busy, a_alarm, a_done;
    logic [2:0] b_ev, b_run, b_max;
    logic b_busy, b_alarm, b_done;
    logic sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zero_event_monitor dut_a (
        .clock(clk), .reset(reset), .enable(enable), .y_in(y_in), .clear(clear),
        .event_count(a_ev), .run_len(a_run), .max_run(a_max),
        .busy(a_busy), .alarm(a_alarm), .window_done(a_done)
    );

    zero_event_monitor #(.CNT_W(3), .WINDOW(12), .THRESH(8)) dut_b (
        .clock(clk), .reset(reset), .enable(enable), .y_in(y_in), .clear(clear),
        .event_count(b_ev), .run_len(b_run), .max_run(b_max),
        .busy(b_busy), .alarm(b_alarm), .window_done(b_done)
    );

    wire [7:0] o_ev   = sel ? {5'b0, b_ev}  : a_ev;
    wire [7:0] o_run  = sel ? {5'b0, b_run} : a_run;
    wire [7:0] o_max  = sel ? {5'b0, b_max} : a_max;
    wire       o_busy = sel ? b_busy  : a_busy;
    wire       o_alrm = sel ? b_alarm : a_alarm;
    wire       o_done = sel ? b_done  : a_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Statistics implied by a sample sequence, saturated at maxv.
    function automatic void model(input bit q[$], input int maxv,
                                  output int ev, output int run, output int mr);
        int cur = 0;
        ev = 0; mr = 0;
        foreach (q[i]) begin
            if (q[i]) begin
                ev++; cur++;
                if (cur > mr) mr = cur;
            end else begin
                cur = 0;
            end
        end
        if (ev > maxv) ev = maxv;
        run = (cur > maxv) ? maxv : cur;
        if (mr > maxv) mr = maxv;
    endfunction

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; y_in = 1'b0; clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Starts a window from IDLE and checks every sample; leaves enable high.
    task automatic run_window(input bit which, input int wlen, input int thr, input int cw,
                              input bit s[$], input string name, output bit alarmed);
        bit pre[$];
        int maxv = (1 << cw) - 1;
        int ev, run, mr;
        bit e_alarm, e_done, e_busy;
        sel = which; alarmed = 1'b0;
        enable = 1'b1; y_in = 1'b0; clear = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b1 || o_ev !== 8'd0 || o_run !== 8'd0 || o_max !== 8'd0) begin
            errors++;
            $display("FAIL %s start: busy=%0b ev=%0d run=%0d max=%0d, want busy=1 and zero counters",
                     name, o_busy, o_ev, o_run, o_max);
        end
        for (int k = 0; k < s.size(); k++) begin
            y_in = s[k];
            tick();
            pre.push_back(s[k]);
            model(pre, maxv, ev, run, mr);
            e_alarm = (thr <= maxv) && (ev >= thr);
            e_done  = !e_alarm && (pre.size() == wlen);
            e_busy  = !e_alarm && !e_done;
            checks++;
            if (o_ev !== 8'(ev) || o_run !== 8'(run) || o_max !== 8'(mr)) begin
                errors++;
                $display("FAIL %s sample %0d counters: ev=%0d run=%0d max=%0d, want %0d %0d %0d",
                         name, k + 1, o_ev, o_run, o_max, ev, run, mr);
            end
            checks++;
            if (o_busy !== e_busy || o_alrm !== e_alarm || o_done !== e_done) begin
                errors++;
                $display("FAIL %s sample %0d flags: busy=%0b alarm=%0b done=%0b, want %0b %0b %0b",
                         name, k + 1, o_busy, o_alrm, o_done, e_busy, e_alarm, e_done);
            end
            if (!e_busy) begin
                alarmed = e_alarm;
                break;
            end
        end
        y_in = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            reset = 1'b0;
            enable = 1'($urandom); y_in = 1'($urandom); clear = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enable = 1'($urandom); y_in = 1'($urandom); clear = 1'($urandom);
            tick();
        end
        checks++;
        if ({a_ev, a_run, a_max, a_busy, a_alarm, a_done} !== 27'd0 ||
            {b_ev, b_run, b_max, b_busy, b_alarm, b_done} !== 12'd0) begin
            errors++;
            $display("FAIL reset: a=%h b=%h, want all zero",
                     {a_ev, a_run, a_max, a_busy, a_alarm, a_done},
                     {b_ev, b_run, b_max, b_busy, b_alarm, b_done});
        end
        reset = 1'b0; enable = 1'b0; y_in = 1'b0; clear = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: busy=%0b alarm=%0b, want 0 0", a_busy, a_alarm);
        end
    endtask

    task automatic test_sparse();
        bit s[$];
        bit al;
        for (int i = 1; i <= 16; i++) s.push_back(i == 3 || i == 9);
        run_window(1'b0, 16, 4, 8, s, "sparse", al);
        // enable stays high: DONE -> IDLE -> new window.
        tick();
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_ev !== 8'd2 || a_max !== 8'd1) begin
            errors++;
            $display("FAIL sparse after_done: done=%0b busy=%0b ev=%0d max=%0d, want 0 0 2 1",
                     a_done, a_busy, a_ev, a_max);
        end
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_ev !== 8'd0 || a_max !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back restart: busy=%0b ev=%0d max=%0d, want 1 0 0",
                     a_busy, a_ev, a_max);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_alarm_hold();
        bit s[$];
        bit al;
        for (int i = 1; i <= 16; i++) s.push_back(i <= 4);
        run_window(1'b0, 16, 4, 8, s, "alarm", al);
        for (int i = 0; i < 10; i++) begin
            y_in = 1'(i); enable = 1'($urandom); clear = 1'b0;
            tick();
            checks++;
            if (a_alarm !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 ||
                a_ev !== 8'd4 || a_run !== 8'd4 || a_max !== 8'd4) begin
                errors++;
                $display("FAIL alarm hold %0d: alarm=%0b busy=%0b ev=%0d run=%0d max=%0d, want 1 0 4 4 4",
                         i, a_alarm, a_busy, a_ev, a_run, a_max);
            end
        end
        enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (a_alarm !== 1'b0 || a_busy !== 1'b0 || a_ev !== 8'd4 || a_max !== 8'd4) begin
            errors++;
            $display("FAIL alarm clear: alarm=%0b busy=%0b ev=%0d max=%0d, want 0 0 4 4",
                     a_alarm, a_busy, a_ev, a_max);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (a_alarm !== 1'b0 || a_busy !== 1'b0 || a_ev !== 8'd4) begin
            errors++;
            $display("FAIL clear_idle: alarm=%0b busy=%0b ev=%0d, want 0 0 4", a_alarm, a_busy, a_ev);
        end
    endtask

    task automatic test_final_sample_alarm();
        bit s[$];
        bit al;
        for (int i = 1; i <= 16; i++) s.push_back(i == 2 || i == 5 || i == 9 || i == 16);
        run_window(1'b0, 16, 4, 8, s, "final_alarm", al);
        checks++;
        if (al !== 1'b1 || a_alarm !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL final_alarm: alarm=%0b done=%0b, want 1 0", a_alarm, a_done);
        end
        enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        enable = 1'b1; y_in = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            y_in = (i % 2 == 1);
            tick();
        end
        checks++;
        if (a_ev !== 8'd3 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: ev=%0d busy=%0b, want 3 1", a_ev, a_busy);
        end
        reset = 1'b1; y_in = 1'b1;
        tick();
        checks++;
        if ({a_ev, a_run, a_max, a_busy, a_alarm, a_done} !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid: outputs=%h, want 0", {a_ev, a_run, a_max, a_busy, a_alarm, a_done});
        end
        reset = 1'b0; y_in = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_ev !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid restart: busy=%0b ev=%0d, want 1 0", a_busy, a_ev);
        end
        y_in = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_ev !== 8'd1 || a_run !== 8'd1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%0b ev=%0d run=%0d done=%0b, want 0 1 1 0",
                     a_busy, a_ev, a_run, a_done);
        end
        y_in = 1'b0;
    endtask

    task automatic test_saturate();
        bit s[$];
        bit al;
        for (int i = 1; i <= 12; i++) s.push_back(1'b1);
        run_window(1'b1, 12, 8, 3, s, "saturate", al);
        checks++;
        if (b_done !== 1'b1 || b_alarm !== 1'b0 || b_ev !== 3'd7 || b_max !== 3'd7) begin
            errors++;
            $display("FAIL saturate end: done=%0b alarm=%0b ev=%0d max=%0d, want 1 0 7 7",
                     b_done, b_alarm, b_ev, b_max);
        end
        enable = 1'b0;
        tick();
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            bit s[$];
            bit al;
            for (int i = 0; i < 16; i++) s.push_back($urandom_range(0, 4) == 0);
            run_window(1'b0, 16, 4, 8, s, $sformatf("random%0d", w), al);
            enable = 1'b0; clear = al;
            tick();
            clear = 1'b0;
            checks++;
            if (a_alarm !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL random%0d exit: alarm=%0b done=%0b busy=%0b, want 0 0 0",
                         w, a_alarm, a_done, a_busy);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1; enable = 1'b0; y_in = 1'b0; clear = 1'b0;
        test_reset();
        do_reset();
        test_sparse();
        do_reset();
        test_alarm_hold();
        do_reset();
        test_final_sample_alarm();
        do_reset();
        test_reset_mid();
        do_reset();
        test_saturate();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
